// File: rtl/cache_skid_reg.sv
// rtl/cache_skid_reg.sv - elastic valid/ready pipeline stage with 2-entry skid buffer
//
// Purpose:
//   Cache pipeline stage register with a valid/ready handshake.
//   It holds up to two entries: a main register, which drives out_data, and a skid register.
//   in_ready is decoded only from the stage state, so there is no combinational path from out_ready to in_ready.
//   With out_ready held high the stage passes one transfer per cycle.
//
// Optional feature:
//   `define CACHE_SKID_STALL_CNT_EN builds a saturating downstream-stall counter.
//   When it is not defined, stall_cycles is tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   flush        in   discard all held entries (highest priority)
//   in_valid     in   upstream payload valid
//   in_ready     out  stage can accept (state-only decode)
//   in_data      in   upstream payload [WIDTH]
//   out_valid    out  out_data valid
//   out_ready    in   downstream accepts this cycle
//   out_data     out  head payload, straight from the main register [WIDTH]
//   count        out  occupancy 0..2
//   stall_cycles out  cycles with out_valid & ~out_ready & ~flush [STALL_CNT_W]

module cache_skid_reg #(
  parameter int WIDTH          = 64,
  parameter bit CLEAR_ON_FLUSH = 1'b0,
  parameter int STALL_CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [1:0]             count,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             accept, emit;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_data  = main_q;
  assign count     = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // A same-cycle accept is dropped.
      // A same-cycle emit has already been seen downstream.
      state_nxt = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_nxt = '0;
        skid_nxt = '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_nxt = in_data;
          end else if (accept) begin
            // Downstream is stalled, so the new entry parks in the skid register.
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the head can move.
          if (emit) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

`ifdef CACHE_SKID_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !flush && !(&stall_q)) begin
      stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_skid_reg.sv
// tb/tb_cache_skid_reg.sv - directed self-checking bench for cache_skid_reg

module tb_cache_skid_reg;

  localparam int W   = 16;
  localparam int SW  = 4;
  localparam bit CLR = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    count;
  logic [SW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  cache_skid_reg #(
    .WIDTH(W),
    .CLEAR_ON_FLUSH(CLR),
    .STALL_CNT_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_count",     32'(count),        32'd0);
    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_out_data",  32'(out_data),     32'h0);
    check("rst_stall",     32'(stall_cycles), 32'd0);

    // Streaming: one transfer per cycle, count stays at 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step();
      check("stream_data",  32'(out_data),  32'(i));
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_count", 32'(count),     32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_count", 32'(count),     32'd0);
    check("stream_drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: the third word must wait until the skid drains.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h11; step();
    check("bp_one_count", 32'(count), 32'd1);
    in_data = 16'h22; step();
    check("bp_full_count", 32'(count),    32'd2);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_head",  32'(out_data), 32'h11);
    in_data = 16'h33; step();
    check("bp_ignored_count", 32'(count),    32'd2);
    check("bp_ignored_head",  32'(out_data), 32'h11);
    out_ready = 1'b1; step();
    check("bp_drain1_data",  32'(out_data), 32'h22);
    check("bp_drain1_count", 32'(count),    32'd1);
    check("bp_drain1_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_drain2_data",  32'(out_data), 32'h33);
    check("bp_drain2_count", 32'(count),    32'd1);
    step();
    check("bp_drain3_count", 32'(count), 32'd0);

    // Simultaneous accept and emit in ONE.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h40; step();
    check("sim_hold_data", 32'(out_data), 32'h40);
    out_ready = 1'b1; in_data = 16'h41; step();
    check("sim_count", 32'(count),    32'd1);
    check("sim_data",  32'(out_data), 32'h41);
    in_valid = 1'b0; step();
    check("sim_drain_count", 32'(count), 32'd0);

    // Flush while full, with a concurrent offer that must be dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h5; step();
    in_data = 16'h6; step();
    check("fl_pre_count", 32'(count), 32'd2);
    in_data = 16'h7; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count",    32'(count),     32'd0);
    check("fl_valid",    32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready),  32'd1);
    check("fl_data",     32'(out_data),  CLR ? 32'h0 : 32'h5);
    out_ready = 1'b1; step();
    check("fl_no_emit_valid", 32'(out_valid), 32'd0);
    check("fl_no_emit_count", 32'(count),     32'd0);

    // Asynchronous reset in the middle of a cycle while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hA; step();
    in_data = 16'hB; step();
    in_valid = 1'b0;
    check("ar_pre_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("ar_valid",    32'(out_valid), 32'd0);
    check("ar_count",    32'(count),     32'd0);
    check("ar_in_ready", 32'(in_ready),  32'd1);
    check("ar_data",     32'(out_data),  32'h0);
    step();
    rst = 1'b0;
    step();
    check("ar_stall_clear", 32'(stall_cycles), 32'd0);

    // Stall counter: increments while stalled and saturates at all-ones.
    in_valid = 1'b1; in_data = 16'h99; step();
    in_valid = 1'b0;
    check("st_start", 32'(stall_cycles), 32'd0);
    step(); step(); step();
`ifdef CACHE_SKID_STALL_CNT_EN
    check("st_three", 32'(stall_cycles), 32'd3);
`else
    check("st_three", 32'(stall_cycles), 32'd0);
`endif
    for (int i = 0; i < 17; i++) step();
`ifdef CACHE_SKID_STALL_CNT_EN
    check("st_sat", 32'(stall_cycles), 32'd15);
`else
    check("st_sat", 32'(stall_cycles), 32'd0);
`endif
    check("st_head", 32'(out_data), 32'h99);
    out_ready = 1'b1; step();
    check("st_drain_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
